// File: rtl/reg_bank_write_arbiter_pkg.sv
// Shared state encoding, default sizing and the word-select decode helper
// for the register bank write arbiter.
package reg_bank_write_arbiter_pkg;

  localparam int N_DEF     = 4;
  localparam int DEPTH_DEF = 16;
  localparam int AW_DEF    = 4;
  localparam int DW_DEF    = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ACK  = 2'd2
  } state_e;

  // One bit of a one-hot decode: true when word idx is addressed.
  function automatic logic onehot_hit(
    input int unsigned addr,
    input int unsigned idx
  );
    return addr == idx;
  endfunction

endpackage

// File: rtl/reg_bank_write_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr_i.
// Shared by every round-robin resource; no state of its own.
module rr_arbiter
  import reg_bank_write_arbiter_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int IW = $clog2(N_DEF)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);

  logic [IW-1:0] j;

  // Scan farthest-first so the nearest requester to ptr_i wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    j     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = IW'((32'(ptr_i) + k) % N);
      if (req_i[j]) begin
        gnt_o    = '0;
        gnt_o[j] = 1'b1;
        idx_o    = j;
      end
    end
  end

endmodule

// File: rtl/reg_bank_write_arbiter.sv
// Round-robin write arbiter owning every register bank load strobe.
// Optional per-word write protection: define REG_BANK_WRITE_PROTECT_EN.
module reg_bank_write_arbiter
  import reg_bank_write_arbiter_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic             Clk,
  input  logic             reset,
`ifdef REG_BANK_WRITE_PROTECT_EN
  input  logic [DEPTH-1:0] prot_mask_in,
  input  logic             prot_load,
`endif
  input  logic [N-1:0]     req,
  input  logic [N*AW-1:0]  wr_addr_in,
  input  logic [N*DW-1:0]  wr_data_in,
  output logic [N-1:0]     grant,
  output logic [N-1:0]     ack,
  output logic             err,
  output logic             busy,
  output logic [DEPTH-1:0] load_vec,
  output logic [DW-1:0]    wr_data_out
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  state_e           state_q;
  logic [IW-1:0]    rr_q;
  logic [IW-1:0]    rr_d;
  logic [IW-1:0]    win_q;
  logic [IW-1:0]    win_idx;
  logic [N-1:0]     win_oh;
  logic             drop_q;
  logic             drop_d;
  logic             in_range;
  logic [AW-1:0]    sel_addr;
  logic [DW-1:0]    sel_data;
  logic [DEPTH-1:0] dec;

  rr_arbiter #(
    .N  (N),
    .IW (IW)
  ) u_arb (
    .req_i (req),
    .ptr_i (rr_q),
    .gnt_o (win_oh),
    .idx_o (win_idx)
  );

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (win_oh[i]) begin
        sel_addr = wr_addr_in[i*AW +: AW];
        sel_data = wr_data_in[i*DW +: DW];
      end
    end
  end

  always_comb begin
    dec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      dec[i] = onehot_hit(32'(sel_addr), i);
    end
  end

  assign in_range = 32'(sel_addr) < DEPTH;
  assign rr_d     = (win_q == IW'(N - 1)) ? '0 : win_q + IW'(1);

`ifdef REG_BANK_WRITE_PROTECT_EN
  logic [DEPTH-1:0] prot_q;
  logic [DEPTH-1:0] prot_d;

  // Arbitration checks the mask that will be live during LOAD.
  assign prot_d = prot_load ? prot_mask_in : prot_q;
  assign drop_d = !in_range || ((dec & prot_d) != '0);

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      prot_q <= '0;
    end else begin
      prot_q <= prot_d;
    end
  end
`else
  assign drop_d = !in_range;
`endif

  // Outputs for LOAD are registered on the arbitration edge itself.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rr_q        <= '0;
      win_q       <= '0;
      drop_q      <= 1'b0;
      grant       <= '0;
      ack         <= '0;
      err         <= 1'b0;
      busy        <= 1'b0;
      load_vec    <= '0;
      wr_data_out <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req != '0) begin
            state_q     <= LOAD;
            win_q       <= win_idx;
            drop_q      <= drop_d;
            grant       <= win_oh;
            busy        <= 1'b1;
            load_vec    <= drop_d ? '0 : dec;
            wr_data_out <= drop_d ? '0 : sel_data;
          end
        end
        LOAD: begin
          state_q     <= ACK;
          load_vec    <= '0;
          wr_data_out <= '0;
          ack         <= grant;
          err         <= drop_q;
        end
        ACK: begin
          state_q <= IDLE;
          rr_q    <= rr_d;
          grant   <= '0;
          ack     <= '0;
          err     <= 1'b0;
          busy    <= 1'b0;
        end
        default: begin
          state_q     <= IDLE;
          grant       <= '0;
          ack         <= '0;
          err         <= 1'b0;
          busy        <= 1'b0;
          load_vec    <= '0;
          wr_data_out <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bank_write_arbiter.sv
// Bench for reg_bank_write_arbiter: directed cases plus randomized requesters
// scored against a cycle-numbered transaction model.
module tb_reg_bank_write_arbiter;

  localparam int N     = 4;
  localparam int DEPTH = 12;
  localparam int AW    = 4;
  localparam int DW    = 8;

  logic             Clk = 1'b0;
  logic             reset;
  logic [N-1:0]     req;
  logic [N*AW-1:0]  wr_addr_in;
  logic [N*DW-1:0]  wr_data_in;
  logic [N-1:0]     grant;
  logic [N-1:0]     ack;
  logic             err;
  logic             busy;
  logic [DEPTH-1:0] load_vec;
  logic [DW-1:0]    wr_data_out;
  logic [DEPTH-1:0] prot_mask_in;
  logic             prot_load;

  logic [AW-1:0] a_r [N];
  logic [DW-1:0] d_r [N];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  int          m_load_at;
  int          m_ack_at;
  int          m_owner;
  int          m_addr;
  int          m_ptr;
  logic [7:0]  m_data;
  bit          m_drop;
  logic [DEPTH-1:0] m_prot;

  always #5 Clk = ~Clk;

  always_comb begin
    wr_addr_in = '0;
    wr_data_in = '0;
    for (int i = 0; i < N; i++) begin
      wr_addr_in[i*AW +: AW] = a_r[i];
      wr_data_in[i*DW +: DW] = d_r[i];
    end
  end

  reg_bank_write_arbiter #(
    .N(N), .DEPTH(DEPTH), .AW(AW), .DW(DW)
  ) dut (
    .Clk         (Clk),
    .reset       (reset),
`ifdef REG_BANK_WRITE_PROTECT_EN
    .prot_mask_in(prot_mask_in),
    .prot_load   (prot_load),
`endif
    .req         (req),
    .wr_addr_in  (wr_addr_in),
    .wr_data_in  (wr_data_in),
    .grant       (grant),
    .ack         (ack),
    .err         (err),
    .busy        (busy),
    .load_vec    (load_vec),
    .wr_data_out (wr_data_out)
  );

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_load_at = -10;
    m_ack_at  = -10;
    m_owner   = 0;
    m_addr    = 0;
    m_data    = '0;
    m_drop    = 1'b0;
    m_ptr     = 0;
    m_prot    = '0;
  endtask

  // Decide what the coming edge does, from the inputs now applied.
  task automatic predict();
    int e;
    int w;
    logic [DEPTH-1:0] mask_n;
    e = cyc + 1;
    if (reset) begin
      model_reset();
      return;
    end
    mask_n = m_prot;
`ifdef REG_BANK_WRITE_PROTECT_EN
    if (prot_load) mask_n = prot_mask_in;
`endif
    m_prot = mask_n;
    if (cyc > m_ack_at && req != '0) begin
      w = -1;
      for (int k = 0; k < N; k++) begin
        if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      end
      m_owner   = w;
      m_addr    = int'(a_r[w]);
      m_data    = d_r[w];
      m_load_at = e;
      m_ack_at  = e + 1;
      m_drop    = m_addr >= DEPTH;
      if (!m_drop && mask_n[m_addr]) m_drop = 1'b1;
      m_ptr     = (w + 1) % N;
    end
  endtask

  task automatic check_cycle();
    logic [DEPTH-1:0] e_lv;
    logic [N-1:0]     e_g;
    logic [N-1:0]     e_a;
    logic             e_err;
    e_lv  = '0;
    e_g   = '0;
    e_a   = '0;
    e_err = 1'b0;
    if (cyc == m_load_at || cyc == m_ack_at) e_g[m_owner] = 1'b1;
    if (cyc == m_load_at && !m_drop) e_lv[m_addr] = 1'b1;
    if (cyc == m_ack_at) begin
      e_a[m_owner] = 1'b1;
      e_err        = m_drop;
    end
    check("grant", 32'(grant), 32'(e_g));
    check("ack", 32'(ack), 32'(e_a));
    check("err", 32'(err), 32'(e_err));
    check("busy", 32'(busy), 32'(e_g != '0));
    check("load_vec", 32'(load_vec), 32'(e_lv));
    check("lv_onehot", 32'($countones(load_vec) <= 1), 32'd1);
    if (e_lv != '0) check("wr_data", 32'(wr_data_out), 32'(m_data));
  endtask

  task automatic tick();
    predict();
    @(posedge Clk);
    cyc++;
    @(negedge Clk);
    check_cycle();
  endtask

  task automatic rand_requesters();
    for (int i = 0; i < N; i++) begin
      if (ack[i]) begin
        if ($urandom_range(1) == 1) begin
          a_r[i] = AW'($urandom_range(15));
          d_r[i] = DW'($urandom);
        end else begin
          req[i] = 1'b0;
        end
      end else if (req[i]) begin
        if (grant[i] && $urandom_range(3) == 0) begin
          a_r[i] = AW'($urandom_range(15));
          d_r[i] = DW'($urandom);
        end else if ($urandom_range(31) == 0) begin
          req[i] = 1'b0;
        end
      end else if ($urandom_range(3) == 0) begin
        req[i] = 1'b1;
        a_r[i] = AW'($urandom_range(15));
        d_r[i] = DW'($urandom);
      end
    end
`ifdef REG_BANK_WRITE_PROTECT_EN
    prot_load    = ($urandom_range(49) == 0);
    prot_mask_in = DEPTH'($urandom) & DEPTH'($urandom);
`endif
  endtask

  int ord [8];
  int at  [8];
  int nrec;
  int exp_ord [5] = '{0, 1, 2, 3, 0};

  initial begin
    reset        = 1'b1;
    req          = '0;
    prot_mask_in = '0;
    prot_load    = 1'b0;
    for (int i = 0; i < N; i++) begin
      a_r[i] = '0;
      d_r[i] = '0;
    end
    model_reset();
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_lv", 32'(load_vec), 32'd0);
    check("rst_wd", 32'(wr_data_out), 32'd0);
    reset = 1'b0;

    // single write
    req[2] = 1'b1; a_r[2] = 4'd5; d_r[2] = 8'hA7;
    tick();
    check("single_lv", 32'(load_vec), 32'h020);
    check("single_wd", 32'(wr_data_out), 32'hA7);
    tick();
    check("single_ack", 32'(ack), 32'h4);
    check("single_err", 32'(err), 32'd0);
    req[2] = 1'b0;
    tick();

    // out of range (rr now 3, only requester 0 asks)
    req[0] = 1'b1; a_r[0] = 4'd13; d_r[0] = 8'h5C;
    tick();
    check("oor_lv", 32'(load_vec), 32'd0);
    tick();
    check("oor_ack", 32'(ack), 32'h1);
    check("oor_err", 32'(err), 32'd1);
    req[0] = 1'b0;
    tick();

    // late data change
    req[1] = 1'b1; a_r[1] = 4'd3; d_r[1] = 8'h11;
    tick();
    d_r[1] = 8'h22;
    check("late_wd", 32'(wr_data_out), 32'h11);
    check("late_lv", 32'(load_vec), 32'h008);
    tick();
    req[1] = 1'b0;
    tick();

    // reset during LOAD of requester 1 (rr would otherwise become 2)
    req[1] = 1'b1; a_r[1] = 4'd4; d_r[1] = 8'h66;
    tick();
    check("pre_rst_grant", 32'(grant), 32'h2);
    reset = 1'b1;
    #1;
    check("mid_rst_lv", 32'(load_vec), 32'd0);
    check("mid_rst_grant", 32'(grant), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    model_reset();
    req = 4'b0110;
    a_r[1] = 4'd7; d_r[1] = 8'h77;
    a_r[2] = 4'd9; d_r[2] = 8'h99;
    tick();
    reset = 1'b0;
    tick();
    check("post_rst_first", 32'(grant), 32'h2);
    tick();
    req = '0;
    tick();

    // round robin from a fresh pointer
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req = '1;
    for (int i = 0; i < N; i++) begin
      a_r[i] = AW'(i + 2);
      d_r[i] = DW'(8'h30 + i);
    end
    nrec = 0;
    for (int t = 0; t < 15; t++) begin
      tick();
      if (load_vec != '0 && nrec < 8) begin
        for (int i = 0; i < N; i++) if (grant[i]) ord[nrec] = i;
        at[nrec] = cyc;
        nrec++;
      end
      for (int i = 0; i < N; i++) begin
        if (ack[i]) a_r[i] = AW'($urandom_range(DEPTH - 1));
      end
    end
    check("rr_count", 32'(nrec), 32'd5);
    for (int k = 0; k < 5; k++) begin
      check("rr_order", 32'(ord[k]), 32'(exp_ord[k]));
      if (k > 0) check("rr_space", 32'(at[k] - at[k-1]), 32'd3);
    end
    req = '0;
    tick();
    tick();

`ifdef REG_BANK_WRITE_PROTECT_EN
    prot_mask_in = 12'h001;
    prot_load    = 1'b1;
    tick();
    prot_load = 1'b0;
    req[0] = 1'b1; a_r[0] = 4'd0; d_r[0] = 8'hEE;
    tick();
    check("prot_lv", 32'(load_vec), 32'd0);
    tick();
    check("prot_err", 32'(err), 32'd1);
    a_r[0] = 4'd1; d_r[0] = 8'h3C;
    tick();
    tick();
    check("prot_ok_lv", 32'(load_vec), 32'h002);
    tick();
    check("prot_ok_err", 32'(err), 32'd0);
    req = '0;
    tick();
`endif

    for (int t = 0; t < 2000; t++) begin
      rand_requesters();
      tick();
    end
    req       = '0;
    prot_load = 1'b0;
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
